// File: rtl/pe_ctrl_gen.sv
// pe_ctrl_gen: sequences MACC accumulate passes over a PE buffer, tracks the write-back
// latency, then flushes the accumulated entries out through write_valid.
module pe_ctrl_gen #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH         = 16,
    parameter int PIPE_LAT          = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PE_BUF_ADDR_WIDTH-1:0]      cfg_num_outputs_m1,
    input  logic [CNT_WIDTH-1:0]              cfg_num_passes_m1,
    input  logic [2:0]                        cfg_op_code,
    input  logic                              in_valid,
    output logic [10+2*PE_BUF_ADDR_WIDTH-1:0] ctrl,
    output logic                              src_2_sel,
    output logic                              busy,
    output logic                              done
);
    localparam int AW = PE_BUF_ADDR_WIDTH;
    localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(PIPE_LAT - 1);
    localparam logic SRC_2_BIAS = 1'b0;
    localparam logic SRC_2_BUF  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACC    = 3'd1,
        S_DRAIN  = 3'd2,
        S_FLUSH  = 3'd3,
        S_FDRAIN = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Handshake: no back-pressure anywhere. start is a one-cycle request honoured only in
    // IDLE; in_valid sampled high on an edge while in ACC makes the next cycle an issue.
    state_t               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        n_m1_q, n_m1_d;
    logic [CNT_WIDTH-1:0] pass_q, pass_d;
    logic [CNT_WIDTH-1:0] p_m1_q, p_m1_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [2:0]           op_cfg_q, op_cfg_d;

    logic                 acc_iss;
    logic                 fl_iss;
    logic [AW-1:0]        iss_addr;
    logic [2:0]           iss_op;
    logic                 sel_d;
    logic                 busy_d;
    logic                 done_d;

    logic [AW-1:0]        rd_addr_q;
    logic [AW-1:0]        wr_addr_q;
    logic                 flush_q;
    logic                 write_valid_q;
    logic                 write_req_q;
    logic                 read_req_q;
    logic                 enable_q;
    logic [2:0]           op_out_q;

    logic                 wb_v [PIPE_LAT];
    logic [AW-1:0]        wb_a [PIPE_LAT];
    logic                 fl_v [PIPE_LAT];

    // Decide what the next cycle looks like; every output is registered from these.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        n_m1_d   = n_m1_q;
        pass_d   = pass_q;
        p_m1_d   = p_m1_q;
        lat_d    = lat_q;
        op_cfg_d = op_cfg_q;
        acc_iss  = 1'b0;
        fl_iss   = 1'b0;
        iss_addr = addr_q;
        iss_op   = op_cfg_q;
        sel_d    = SRC_2_BUF;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                sel_d  = SRC_2_BIAS;
                if (start && !done) begin
                    n_m1_d   = cfg_num_outputs_m1;
                    p_m1_d   = cfg_num_passes_m1;
                    op_cfg_d = cfg_op_code;
                    iss_op   = cfg_op_code;
                    iss_addr = '0;
                    pass_d   = '0;
                    addr_d   = '0;
                    lat_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_ACC;
                    if (in_valid) begin
                        acc_iss = 1'b1;
                        if (cfg_num_outputs_m1 == '0) begin
                            state_d = S_DRAIN;
                        end else begin
                            addr_d = AW'(1);
                        end
                    end
                end
            end
            S_ACC: begin
                sel_d = (pass_q == '0) ? SRC_2_BIAS : SRC_2_BUF;
                if (in_valid) begin
                    acc_iss = 1'b1;
                    if (addr_q == n_m1_q) begin
                        state_d = S_DRAIN;
                        lat_d   = '0;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    lat_d  = '0;
                    addr_d = '0;
                    // Comparing before incrementing keeps the pass counter from ever wrapping.
                    if (pass_q != p_m1_q) begin
                        pass_d  = pass_q + CNT_WIDTH'(1);
                        state_d = S_ACC;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_FLUSH: begin
                fl_iss = 1'b1;
                if (addr_q == n_m1_q) begin
                    state_d = S_FDRAIN;
                    lat_d   = '0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_FDRAIN: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            n_m1_q        <= '0;
            pass_q        <= '0;
            p_m1_q        <= '0;
            lat_q         <= '0;
            op_cfg_q      <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            flush_q       <= 1'b0;
            write_valid_q <= 1'b0;
            write_req_q   <= 1'b0;
            read_req_q    <= 1'b0;
            enable_q      <= 1'b0;
            op_out_q      <= '0;
            src_2_sel     <= SRC_2_BIAS;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wb_v[i] <= 1'b0;
                wb_a[i] <= '0;
                fl_v[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            n_m1_q     <= n_m1_d;
            pass_q     <= pass_d;
            p_m1_q     <= p_m1_d;
            lat_q      <= lat_d;
            op_cfg_q   <= op_cfg_d;
            read_req_q <= acc_iss | fl_iss;
            enable_q   <= acc_iss;
            flush_q    <= fl_iss;
            op_out_q   <= (acc_iss | fl_iss) ? iss_op : 3'd0;
            if (acc_iss | fl_iss) begin
                rd_addr_q <= iss_addr;
            end
            src_2_sel <= sel_d;
            busy      <= busy_d;
            done      <= done_d;
            // Slot 0 lines up with the issue cycle, so the tap after the last slot is t+PIPE_LAT.
            wb_v[0] <= acc_iss;
            wb_a[0] <= iss_addr;
            fl_v[0] <= fl_iss;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wb_v[i] <= wb_v[i-1];
                wb_a[i] <= wb_a[i-1];
                fl_v[i] <= fl_v[i-1];
            end
            write_req_q   <= wb_v[PIPE_LAT-1];
            wr_addr_q     <= wb_v[PIPE_LAT-1] ? wb_a[PIPE_LAT-1] : '0;
            write_valid_q <= fl_v[PIPE_LAT-1];
        end
    end

    assign ctrl = {1'b0, 1'b0, rd_addr_q, wr_addr_q, flush_q, write_valid_q,
                   write_req_q, read_req_q, enable_q, op_out_q};

endmodule

// File: tb/tb_pe_ctrl_gen.sv
// Directed bench for pe_ctrl_gen: per-scenario cycle masks of expected events, checked
// cycle by cycle, plus a hand-written mid-run reset abort.
module tb_pe_ctrl_gen;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int LAT = 3;
  localparam int WIN = 40;
  localparam logic BIAS = 1'b0;
  localparam logic BUFS = 1'b1;

  logic clk;
  logic reset;
  logic start;
  logic in_valid;
  logic [AW-1:0] cfg_num_outputs_m1;
  logic [CW-1:0] cfg_num_passes_m1;
  logic [2:0] cfg_op_code;
  logic [10+2*AW-1:0] ctrl;
  logic src_2_sel;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;
  int cur_vec = 0;

  pe_ctrl_gen #(
    .PE_BUF_ADDR_WIDTH(AW),
    .CNT_WIDTH(CW),
    .PIPE_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_num_outputs_m1(cfg_num_outputs_m1),
    .cfg_num_passes_m1(cfg_num_passes_m1),
    .cfg_op_code(cfg_op_code),
    .in_valid(in_valid),
    .ctrl(ctrl),
    .src_2_sel(src_2_sel),
    .busy(busy),
    .done(done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [2:0] f_op;
  logic f_en, f_rd, f_wr, f_wv, f_fl;
  logic [AW-1:0] f_wr_addr, f_rd_addr;
  logic [1:0] f_norm;
  assign f_op      = ctrl[2:0];
  assign f_en      = ctrl[3];
  assign f_rd      = ctrl[4];
  assign f_wr      = ctrl[5];
  assign f_wv      = ctrl[6];
  assign f_fl      = ctrl[7];
  assign f_wr_addr = ctrl[8+AW-1:8];
  assign f_rd_addr = ctrl[8+2*AW-1:8+AW];
  assign f_norm    = ctrl[9+2*AW:8+2*AW];

  typedef struct {
    logic [AW-1:0] n_m1;
    logic [CW-1:0] p_m1;
    logic [2:0]    op;
    int            bubble;
    int            iv_off;
    logic          extra_start;
    logic [63:0]   rd;
    logic [63:0]   fl;
    logic [63:0]   wr;
    logic [63:0]   wv;
    logic [63:0]   bias;
    int            done_c;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] n_m1, input logic [CW-1:0] p_m1,
                              input logic [2:0] op, input int bubble, input int iv_off,
                              input logic extra, input logic [63:0] rd, input logic [63:0] fl,
                              input logic [63:0] wr, input logic [63:0] wv,
                              input logic [63:0] bias, input int done_c);
    vec_t v;
    v.n_m1 = n_m1; v.p_m1 = p_m1; v.op = op; v.bubble = bubble; v.iv_off = iv_off;
    v.extra_start = extra; v.rd = rd; v.fl = fl; v.wr = wr; v.wv = wv; v.bias = bias;
    v.done_c = done_c;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s cycle %0d: got %0h expected %0h", cur_vec, name, cyc, act, exp);
    end
  endtask

  // driver: start at relative cycle 0, then compare every cycle of the window
  task automatic run_vec(input vec_t v);
    int n;
    int rd_i;
    int wr_i;
    int last_rd;
    logic er, ef;
    n = int'(v.n_m1) + 1;
    rd_i = 0;
    wr_i = 0;
    last_rd = 0;
    @(posedge clk); #1;
    for (int c = 0; c < WIN; c++) begin
      er = v.rd[c];
      ef = v.fl[c];
      chk("read_req", c, 32'(f_rd), 32'(er));
      chk("flush", c, 32'(f_fl), 32'(ef));
      chk("enable", c, 32'(f_en), 32'(er & ~ef));
      chk("write_req", c, 32'(f_wr), 32'(v.wr[c]));
      chk("write_valid", c, 32'(f_wv), 32'(v.wv[c]));
      chk("done", c, 32'(done), 32'(c == v.done_c));
      chk("busy", c, 32'(busy), 32'(c >= 1 && c < v.done_c));
      chk("src_2_sel", c, 32'(src_2_sel),
          32'((c >= 1 && c <= v.done_c && !v.bias[c]) ? BUFS : BIAS));
      chk("norm_fifo", c, 32'(f_norm), 32'd0);
      if (f_rd) begin
        chk("buf_rd_addr", c, 32'(f_rd_addr), 32'(rd_i % n));
        chk("op_code", c, 32'(f_op), 32'(v.op));
        last_rd = rd_i % n;
        rd_i++;
      end else begin
        chk("op_code_idle", c, 32'(f_op), 32'd0);
        if (rd_i > 0) chk("buf_rd_addr_hold", c, 32'(f_rd_addr), 32'(last_rd));
      end
      if (f_wr) begin
        chk("buf_wr_addr", c, 32'(f_wr_addr), 32'(wr_i % n));
        wr_i++;
      end
      // inputs sampled at the end of cycle c; in_valid is presented for the issue at c+1
      if (c == 0) begin
        cfg_num_outputs_m1 = v.n_m1;
        cfg_num_passes_m1  = v.p_m1;
        cfg_op_code        = v.op;
      end else if (c == 1) begin
        cfg_num_outputs_m1 = AW'($urandom_range(0, 1023));
        cfg_num_passes_m1  = CW'($urandom_range(0, 65535));
        cfg_op_code        = ~v.op;
      end
      start = (c == 0) || (v.extra_start && (c == 3 || c == 10));
      in_valid = (c + 1 != v.bubble) && (c + 1 < v.iv_off);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(10'd3, 16'd1, 3'd3, -1, 1000, 1'b0,
                 rng(1,4) | rng(8,11) | rng(15,18), rng(15,18),
                 rng(4,7) | rng(11,14), rng(18,21), rng(1,4), 22);
    vecs[1] = mk(10'd3, 16'd0, 3'd6, 2, 1000, 1'b0,
                 rng(1,1) | rng(3,5) | rng(9,12), rng(9,12),
                 rng(4,4) | rng(6,8), rng(12,15), rng(1,5), 16);
    vecs[2] = mk(10'd0, 16'd0, 3'd5, -1, 1000, 1'b0,
                 rng(1,1) | rng(5,5), rng(5,5), rng(4,4), rng(8,8), rng(1,1), 9);
    vecs[3] = mk(10'd2, 16'd2, 3'd7, -1, 1000, 1'b0,
                 rng(1,3) | rng(7,9) | rng(13,15) | rng(19,21), rng(19,21),
                 rng(4,6) | rng(10,12) | rng(16,18), rng(22,24), rng(1,3), 25);
    vecs[4] = mk(10'd1, 16'd0, 3'd1, 1, 1000, 1'b0,
                 rng(2,3) | rng(7,8), rng(7,8), rng(5,6), rng(10,11), rng(1,3), 12);
    vecs[5] = mk(10'd3, 16'd1, 3'd3, -1, 15, 1'b1,
                 rng(1,4) | rng(8,11) | rng(15,18), rng(15,18),
                 rng(4,7) | rng(11,14), rng(18,21), rng(1,4), 22);

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    cfg_num_outputs_m1 = '0;
    cfg_num_passes_m1 = '0;
    cfg_op_code = '0;
    @(posedge clk); #1;
    chk("reset_ctrl", 0, 32'(ctrl), 32'd0);
    chk("reset_busy", 0, 32'(busy), 32'd0);
    chk("reset_done", 0, 32'(done), 32'd0);
    chk("reset_src_2_sel", 0, 32'(src_2_sel), 32'(BIAS));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // mid-run reset: first scenario, reset asserted in cycle 6, released at cycle 8
    cur_vec = 6;
    @(posedge clk); #1;
    cfg_num_outputs_m1 = 10'd3;
    cfg_num_passes_m1 = 16'd1;
    cfg_op_code = 3'd3;
    start = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_write_req", 6, 32'(f_wr), 32'd1);
    chk("pre_reset_busy", 6, 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 6, 32'(ctrl), 32'd0);
    chk("async_reset_busy", 6, 32'(busy), 32'd0);
    chk("async_reset_done", 6, 32'(done), 32'd0);
    chk("async_reset_src_2_sel", 6, 32'(src_2_sel), 32'(BIAS));
    @(posedge clk); #1;
    chk("held_reset_ctrl", 7, 32'(ctrl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("post_reset_ctrl", 8, 32'(ctrl), 32'd0);
    chk("post_reset_busy", 8, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("post_reset_ctrl", 9, 32'(ctrl), 32'd0);
    chk("post_reset_write_req", 9, 32'(f_wr), 32'd0);
    chk("post_reset_busy", 9, 32'(busy), 32'd0);
    cur_vec = 7;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
